// File: rtl/ltl_monitor_ctrl_if.sv
// Symbol-in and report-out handshakes of the LTL monitor controller.
// The master drives symbols and consumes reports; the controller is the slave.
interface ltl_monitor_ctrl_if #(
  parameter int SYM_W   = 8,
  parameter int NUM_RPT = 4,
  parameter int IDX_W   = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [SYM_W-1:0]   in_symbol;
  logic               in_last;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [NUM_RPT-1:0] rpt_vec;
  logic [IDX_W-1:0]   rpt_index;

  modport master (
    output in_valid,
    output in_symbol,
    output in_last,
    output rpt_ready,
    input  in_ready,
    input  rpt_valid,
    input  rpt_vec,
    input  rpt_index
  );

  modport slave (
    input  in_valid,
    input  in_symbol,
    input  in_last,
    input  rpt_ready,
    output in_ready,
    output rpt_valid,
    output rpt_vec,
    output rpt_index
  );
endinterface

// File: rtl/ltl_monitor_ctrl.sv
// Streams a symbol trace into an automaton and queues its non-zero
// reports, tagged with the index of the causing symbol.
module ltl_monitor_ctrl #(
  parameter int SYM_W      = 8,
  parameter int NUM_RPT    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trace_start,
  ltl_monitor_ctrl_if.slave  s_if,
  output logic               am_reset,
  output logic               am_run,
  output logic [SYM_W-1:0]   am_symbols,
  input  logic [NUM_RPT-1:0] am_report,
  output logic               busy,
  output logic               done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               r_init_cnt;
  logic               r_inflight;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_pend_idx;
  logic [SYM_W-1:0]   r_sym;

  logic [NUM_RPT-1:0] r_vec_mem [FIFO_DEPTH];
  logic [IDX_W-1:0]   r_idx_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_count;

  logic [CW:0]        w_occ;
  logic               w_space;
  logic               w_xfer;
  logic               w_enq;
  logic               w_pop;
  logic               w_nonempty;

  // Pending report counts as occupied so a full FIFO can never overflow.
  assign w_occ      = (CW+1)'(r_count) + (CW+1)'(r_inflight);
  assign w_space    = w_occ < (CW+1)'(FIFO_DEPTH);
  assign w_nonempty = r_count != '0;

  assign s_if.in_ready = (r_state == S_STREAM) && w_space;
  assign w_xfer        = s_if.in_valid && s_if.in_ready;

  assign am_run     = w_xfer;
  assign am_symbols = w_xfer ? s_if.in_symbol : r_sym;
  assign am_reset   = (r_state == S_IDLE) || (r_state == S_INIT);
  assign busy       = r_state != S_IDLE;
  assign done       = r_state == S_DONE;

  assign w_enq = r_inflight && (|am_report) && !trace_start;
  assign w_pop = w_nonempty && s_if.rpt_ready && !trace_start;

  assign s_if.rpt_valid = w_nonempty;
  assign s_if.rpt_vec   = r_vec_mem[r_rp];
  assign s_if.rpt_index = r_idx_mem[r_rp];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = S_IDLE;
      S_INIT:   if (r_init_cnt) w_next = S_STREAM;
      S_STREAM: if (w_xfer && s_if.in_last) w_next = S_DRAIN;
      // The last symbol's report is sampled during this single cycle.
      S_DRAIN:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (trace_start) w_next = S_INIT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init_cnt <= 1'b0;
      r_inflight <= 1'b0;
      r_idx      <= '0;
      r_pend_idx <= '0;
      r_sym      <= '0;
    end else begin
      if (trace_start) begin
        r_init_cnt <= 1'b0;
      end else if (r_state == S_INIT) begin
        r_init_cnt <= 1'b1;
      end
      r_inflight <= w_xfer && !trace_start;
      if (w_xfer) begin
        r_sym      <= s_if.in_symbol;
        r_pend_idx <= r_idx;
      end
      if (trace_start) begin
        r_idx <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_vec_mem[i] <= '0;
        r_idx_mem[i] <= '0;
      end
    end else if (trace_start) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_vec_mem[r_wp] <= am_report;
        r_idx_mem[r_wp] <= r_pend_idx;
        r_wp            <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ltl_monitor_ctrl.sv
// Directed bench for ltl_monitor_ctrl: trace flow, back-pressure,
// report ordering, abort and asynchronous reset.
module tb_ltl_monitor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trace_start = 1'b0;
  logic       am_reset;
  logic       am_run;
  logic [7:0] am_symbols;
  logic [3:0] am_report = 4'b0000;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  ltl_monitor_ctrl_if #(.SYM_W(8), .NUM_RPT(4), .IDX_W(32)) bus ();

  ltl_monitor_ctrl #(
    .SYM_W(8), .NUM_RPT(4), .FIFO_DEPTH(4), .IDX_W(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_start (trace_start),
    .s_if        (bus),
    .am_reset    (am_reset),
    .am_run      (am_run),
    .am_symbols  (am_symbols),
    .am_report   (am_report),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] s, input logic l);
    bus.in_valid  = v;
    bus.in_symbol = s;
    bus.in_last   = l;
    #1;
  endtask

  task automatic start_trace();
    trace_start = 1'b1;
    step();
    trace_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_symbol = 8'h00;
    bus.in_last   = 1'b0;
    bus.rpt_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_am_reset", am_reset, 1);
    chk("rst_am_run", am_run, 0);
    chk("rst_am_sym", am_symbols, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rpt_valid", bus.rpt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    step();
    reset = 1'b0;

    // Idle ignores symbols until a trace starts
    drv(1, 8'hAA, 0);
    step();
    step();
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_am_run", am_run, 0);
    chk("idle_busy", busy, 0);
    chk("idle_am_reset", am_reset, 1);
    drv(0, 8'h00, 0);

    // Trace A: single symbol 0x05 marked last
    start_trace();
    chk("a_c1_am_reset", am_reset, 1);
    chk("a_c1_busy", busy, 1);
    chk("a_c1_in_ready", bus.in_ready, 0);
    step();
    chk("a_c2_am_reset", am_reset, 1);
    chk("a_c2_in_ready", bus.in_ready, 0);
    step();
    chk("a_c3_am_reset", am_reset, 0);
    chk("a_c3_in_ready", bus.in_ready, 1);
    drv(1, 8'h05, 1);
    chk("a_c3_am_run", am_run, 1);
    chk("a_c3_am_sym", am_symbols, 8'h05);
    step();
    drv(0, 8'h77, 0);
    chk("a_c4_in_ready", bus.in_ready, 0);
    chk("a_c4_am_run", am_run, 0);
    chk("a_c4_am_sym_hold", am_symbols, 8'h05);
    chk("a_c4_done", done, 0);
    step();
    chk("a_c5_done", done, 1);
    chk("a_c5_busy", busy, 1);
    step();
    chk("a_c6_done", done, 0);
    chk("a_c6_busy", busy, 0);
    chk("a_c6_rpt_valid", bus.rpt_valid, 0);

    // Trace B: 0x10,0x20,0x30(last); only 0x20 reports
    start_trace();
    step();
    step();
    drv(1, 8'h10, 0);
    chk("b_x0_am_run", am_run, 1);
    step();
    am_report = 4'b0000;
    drv(1, 8'h20, 0);
    step();
    am_report = 4'b1000;
    drv(1, 8'h30, 1);
    chk("b_x2_am_sym", am_symbols, 8'h30);
    chk("b_nobypass", bus.rpt_valid, 0);
    step();
    am_report = 4'b0000;
    drv(0, 8'h00, 0);
    chk("b_rpt_valid", bus.rpt_valid, 1);
    chk("b_rpt_vec", bus.rpt_vec, 4'b1000);
    chk("b_rpt_index", bus.rpt_index, 1);
    chk("b_drain_done", done, 0);
    step();
    chk("b_done", done, 1);
    step();
    chk("b_done_off", done, 0);
    chk("b_retained", bus.rpt_valid, 1);
    bus.rpt_ready = 1'b1;
    step();
    bus.rpt_ready = 1'b0;
    chk("b_popped", bus.rpt_valid, 0);

    // Trace C: back-pressure with every symbol reporting
    am_report = 4'b0001;
    start_trace();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      drv(1, 8'(8'h40 + i), 0);
      chk($sformatf("c_ready%0d", i), bus.in_ready, 1);
      chk($sformatf("c_run%0d", i), am_run, 1);
      step();
    end
    chk("c_full_pend", bus.in_ready, 0);
    step();
    chk("c_full", bus.in_ready, 0);
    chk("c_full_valid", bus.rpt_valid, 1);
    drv(0, 8'h00, 0);
    bus.rpt_ready = 1'b1;
    chk("c_pop0", bus.rpt_index, 0);
    chk("c_vec0", bus.rpt_vec, 4'b0001);
    step();
    chk("c_pop1", bus.rpt_index, 1);
    step();
    chk("c_pop2", bus.rpt_index, 2);
    drv(1, 8'h55, 0);
    chk("c_refill_ready", bus.in_ready, 1);
    step();
    drv(0, 8'h00, 0);
    chk("c_pop3", bus.rpt_index, 3);
    step();
    chk("c_same_valid", bus.rpt_valid, 1);
    chk("c_same_head", bus.rpt_index, 4);
    step();
    bus.rpt_ready = 1'b0;
    chk("c_empty", bus.rpt_valid, 0);

    // Abort with two reports queued
    drv(1, 8'h61, 0);
    step();
    drv(1, 8'h62, 0);
    step();
    drv(0, 8'h00, 0);
    step();
    chk("d_two_valid", bus.rpt_valid, 1);
    chk("d_two_head", bus.rpt_index, 5);
    start_trace();
    chk("d_flushed", bus.rpt_valid, 0);
    chk("d_init1", am_reset, 1);
    step();
    chk("d_init2", am_reset, 1);
    step();
    chk("d_stream", am_reset, 0);
    drv(1, 8'h99, 0);
    chk("d_run", am_run, 1);
    step();
    drv(0, 8'h00, 0);
    am_report = 4'b0010;
    step();
    am_report = 4'b0000;
    chk("d_valid", bus.rpt_valid, 1);
    chk("d_vec", bus.rpt_vec, 4'b0010);
    chk("d_index0", bus.rpt_index, 0);

    // Async reset between edges mid-stream
    drv(1, 8'h3C, 0);
    chk("e_run_pre", am_run, 1);
    #1 reset = 1'b1;
    #1;
    chk("e_am_run", am_run, 0);
    chk("e_am_reset", am_reset, 1);
    chk("e_rpt_valid", bus.rpt_valid, 0);
    chk("e_in_ready", bus.in_ready, 0);
    chk("e_busy", busy, 0);
    drv(0, 8'h00, 0);
    step();
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
